// File: rtl/tlb_query.sv
// rtl/tlb_query.sv - TLBP/TLBR executor: sequential probe and indexed read of the TLB entry store
module tlb_query (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic        op_i,
  input  logic [31:0] index_i,
  input  logic [31:0] entryhi_i,
  output logic [3:0]  tlb_rd_idx_o,
  input  logic [95:0] tlb_rd_entry_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        index_we_o,
  output logic [31:0] index_o,
  output logic        entryhi_we_o,
  output logic [31:0] entryhi_o,
  output logic        entrylo0_we_o,
  output logic [31:0] entrylo0_o,
  output logic        entrylo1_we_o,
  output logic [31:0] entrylo1_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [18:0] key_vpn2;
  logic [7:0]  key_asid;
  logic        was_read;
  logic        match;
  logic        unused;

  assign unused = ^{index_i[31:4], entryhi_i[12:8]};

  // Global entry requires G set in both EntryLo halves.
  assign match = (tlb_rd_entry_i[95:77] == key_vpn2) &&
                 ((tlb_rd_entry_i[71:64] == key_asid) ||
                  (tlb_rd_entry_i[32] && tlb_rd_entry_i[0]));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (op_valid_i) state_nx = op_i ? S_READ : S_PROBE;
      S_PROBE: if (match || tlb_rd_idx_o == 4'd15) state_nx = S_DONE;
      S_READ:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tlb_rd_idx_o <= 4'd0;
      key_vpn2     <= 19'd0;
      key_asid     <= 8'd0;
      was_read     <= 1'b0;
      index_o      <= 32'h0;
      entryhi_o    <= 32'h0;
      entrylo0_o   <= 32'h0;
      entrylo1_o   <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid_i) begin
            was_read <= op_i;
            if (op_i) begin
              tlb_rd_idx_o <= index_i[3:0];
            end else begin
              tlb_rd_idx_o <= 4'd0;
              key_vpn2     <= entryhi_i[31:13];
              key_asid     <= entryhi_i[7:0];
            end
          end
        end
        S_PROBE: begin
          if (match)                      index_o <= {28'b0, tlb_rd_idx_o};
          else if (tlb_rd_idx_o == 4'd15) index_o <= 32'h8000_0000;
          else                            tlb_rd_idx_o <= tlb_rd_idx_o + 4'd1;
        end
        S_READ: begin
          entryhi_o  <= tlb_rd_entry_i[95:64];
          entrylo0_o <= tlb_rd_entry_i[63:32];
          entrylo1_o <= tlb_rd_entry_i[31:0];
        end
        default: ;
      endcase
    end
  end

  assign stall_o       = ((state == S_IDLE) && op_valid_i) || (state == S_PROBE) || (state == S_READ);
  assign done_o        = (state == S_DONE);
  assign index_we_o    = done_o && !was_read;
  assign entryhi_we_o  = done_o && was_read;
  assign entrylo0_we_o = done_o && was_read;
  assign entrylo1_we_o = done_o && was_read;

endmodule

// File: tb/tb_tlb_query.sv
// tb/tb_tlb_query.sv - directed self-checking bench for tlb_query
module tb_tlb_query;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i, op_i;
  logic [31:0] index_i, entryhi_i;
  logic [3:0]  tlb_rd_idx_o;
  logic [95:0] tlb_rd_entry_i;
  logic        stall_o, done_o;
  logic        index_we_o, entryhi_we_o, entrylo0_we_o, entrylo1_we_o;
  logic [31:0] index_o, entryhi_o, entrylo0_o, entrylo1_o;

  logic [95:0] mem [16];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  assign tlb_rd_entry_i = mem[tlb_rd_idx_o];

  tlb_query dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
    .index_i(index_i), .entryhi_i(entryhi_i),
    .tlb_rd_idx_o(tlb_rd_idx_o), .tlb_rd_entry_i(tlb_rd_entry_i),
    .stall_o(stall_o), .done_o(done_o),
    .index_we_o(index_we_o), .index_o(index_o),
    .entryhi_we_o(entryhi_we_o), .entryhi_o(entryhi_o),
    .entrylo0_we_o(entrylo0_we_o), .entrylo0_o(entrylo0_o),
    .entrylo1_we_o(entrylo1_we_o), .entrylo1_o(entrylo1_o)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Default entries never match key 32'h0040_2001 (VPN2 differs, G clear).
  task automatic init_mem();
    for (int i = 0; i < 16; i++)
      mem[i] = {32'hF000_0000 | (32'(i) << 13), 32'h0, 32'h0};
  endtask

  // Issues a request in the current cycle (cycle 0) and advances to cycle 1.
  task automatic issue(input logic op, input logic [31:0] idx, input logic [31:0] hi);
    op_valid_i = 1'b1; op_i = op; index_i = idx; entryhi_i = hi;
    step();
    op_valid_i = 1'b0;
  endtask

  // Advances until done_o, returning the cycle number it was seen in (99 on timeout).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done_o && cyc < 40) begin
      step();
      cyc++;
    end
    if (!done_o) cyc = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid_i = 1'b0; op_i = 1'b0; index_i = 32'h0; entryhi_i = 32'h0;
    step(); step();
    rst = 1'b0;
    n_cmp++;
    if ({stall_o, done_o, index_we_o, entryhi_we_o, entrylo0_we_o, entrylo1_we_o} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b expected 000000",
        {stall_o, done_o, index_we_o, entryhi_we_o, entrylo0_we_o, entrylo1_we_o});
    end
    n_cmp++;
    if ({tlb_rd_idx_o, index_o, entryhi_o, entrylo0_o, entrylo1_o} !== 132'h0) begin
      n_bad++; $display("FAIL reset_data got idx=%0d index=%h hi=%h lo0=%h lo1=%h expected all 0",
        tlb_rd_idx_o, index_o, entryhi_o, entrylo0_o, entrylo1_o);
    end
  endtask

  task automatic test_tlbr();
    init_mem();
    mem[5] = {32'h0040_2001, 32'h0000_1046, 32'h0000_1086};
    op_valid_i = 1'b1; op_i = 1'b1; index_i = 32'd5; entryhi_i = 32'h0;
    #1;
    n_cmp++;
    if (stall_o !== 1'b1) begin n_bad++; $display("FAIL tlbr_stall_c0 got %b expected 1", stall_o); end
    step();
    op_valid_i = 1'b0;
    n_cmp++;
    if ({stall_o, done_o, tlb_rd_idx_o} !== {1'b1, 1'b0, 4'd5}) begin
      n_bad++; $display("FAIL tlbr_c1 got stall=%b done=%b idx=%0d expected 1 0 5", stall_o, done_o, tlb_rd_idx_o);
    end
    step();
    n_cmp++;
    if ({done_o, stall_o, entryhi_we_o, entrylo0_we_o, entrylo1_we_o, index_we_o} !== 6'b101110) begin
      n_bad++; $display("FAIL tlbr_c2_strobes got done=%b stall=%b we=%b%b%b idx_we=%b expected 1 0 111 0",
        done_o, stall_o, entryhi_we_o, entrylo0_we_o, entrylo1_we_o, index_we_o);
    end
    n_cmp++;
    if ({entryhi_o, entrylo0_o, entrylo1_o} !== {32'h0040_2001, 32'h0000_1046, 32'h0000_1086}) begin
      n_bad++; $display("FAIL tlbr_data got %h %h %h expected 00402001 00001046 00001086",
        entryhi_o, entrylo0_o, entrylo1_o);
    end
    step();
    n_cmp++;
    if ({done_o, entryhi_we_o, entryhi_o} !== {1'b0, 1'b0, 32'h0040_2001}) begin
      n_bad++; $display("FAIL tlbr_hold got done=%b we=%b hi=%h expected 0 0 00402001", done_o, entryhi_we_o, entryhi_o);
    end
  endtask

  task automatic test_probe_hit3();
    int stall_bad;
    init_mem();
    mem[3] = {32'h0040_2001, 32'h0, 32'h0};
    stall_bad = 0;
    op_valid_i = 1'b1; op_i = 1'b0; index_i = 32'h0; entryhi_i = 32'h0040_2001;
    #1;
    if (stall_o !== 1'b1) stall_bad++;
    step();
    op_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (stall_o !== 1'b1 || done_o !== 1'b0) stall_bad++;
      step();
    end
    n_cmp++;
    if (stall_bad != 0) begin n_bad++; $display("FAIL probe3_stall got %0d bad cycles expected 0", stall_bad); end
    n_cmp++;
    if ({done_o, index_we_o, entryhi_we_o, stall_o, index_o} !== {4'b1100, 32'h0000_0003}) begin
      n_bad++; $display("FAIL probe3_c5 got done=%b iwe=%b hwe=%b stall=%b index=%h expected 1 1 0 0 00000003",
        done_o, index_we_o, entryhi_we_o, stall_o, index_o);
    end
    step();
  endtask

  task automatic test_probe_miss();
    int idx_bad, cyc;
    init_mem();
    idx_bad = 0;
    issue(1'b0, 32'h0, 32'h0040_2001);
    for (int c = 1; c <= 16; c++) begin
      if (tlb_rd_idx_o !== 4'(c - 1) || stall_o !== 1'b1 || done_o !== 1'b0) idx_bad++;
      if (c < 16) step();
    end
    n_cmp++;
    if (idx_bad != 0) begin n_bad++; $display("FAIL miss_idx_walk got %0d bad cycles expected 0", idx_bad); end
    step();
    cyc = done_o ? 17 : 0;
    n_cmp++;
    if ({cyc, index_we_o, index_o} !== {32'd17, 1'b1, 32'h8000_0000}) begin
      n_bad++; $display("FAIL miss_result got done_cyc=%0d iwe=%b index=%h expected 17 1 80000000", cyc, index_we_o, index_o);
    end
    step();
  endtask

  task automatic test_probe_global();
    int cyc;
    init_mem();
    mem[2] = {32'h0040_2001, 32'h0, 32'h0};
    mem[9] = {32'h0040_2055, 32'h0000_0001, 32'h0000_0001};
    issue(1'b0, 32'h0, 32'h0040_2001);
    wait_done(cyc);
    n_cmp++;
    if ({cyc, index_o} !== {32'd4, 32'd2}) begin
      n_bad++; $display("FAIL global_lowest got cyc=%0d index=%h expected 4 00000002", cyc, index_o);
    end
    step();
    mem[2] = {32'hF000_4000, 32'h0, 32'h0};
    issue(1'b0, 32'h0, 32'h0040_2001);
    wait_done(cyc);
    n_cmp++;
    if ({cyc, index_o} !== {32'd11, 32'd9}) begin
      n_bad++; $display("FAIL global_only got cyc=%0d index=%h expected 11 00000009", cyc, index_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    init_mem();
    issue(1'b0, 32'h0, 32'h0040_2001);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({stall_o, done_o, index_we_o, entryhi_we_o, tlb_rd_idx_o, index_o} !== {8'h0, 32'h0}) begin
      n_bad++; $display("FAIL rst_mid got stall=%b done=%b iwe=%b hwe=%b idx=%0d index=%h expected all 0",
        stall_o, done_o, index_we_o, entryhi_we_o, tlb_rd_idx_o, index_o);
    end
    mem[5] = {32'h0040_2001, 32'h0000_1046, 32'h0000_1086};
    issue(1'b1, 32'd5, 32'h0);
    wait_done(cyc);
    n_cmp++;
    if ({cyc, entryhi_we_o, entrylo1_o} !== {32'd2, 1'b1, 32'h0000_1086}) begin
      n_bad++; $display("FAIL rst_then_tlbr got cyc=%0d hwe=%b lo1=%h expected 2 1 00001086", cyc, entryhi_we_o, entrylo1_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int cyc;
    init_mem();
    mem[2] = {32'h0040_2001, 32'h0, 32'h0};
    mem[9] = {32'h0040_2055, 32'h0000_0001, 32'h0000_0001};
    op_valid_i = 1'b1; op_i = 1'b0; index_i = 32'd9; entryhi_i = 32'h0040_2001;
    step();
    op_i = 1'b1; entryhi_i = 32'hFFFF_FFFF;
    cyc = 1;
    while (!done_o && cyc < 40) begin step(); cyc++; end
    n_cmp++;
    if ({cyc, index_o, entryhi_we_o, stall_o} !== {32'd4, 32'd2, 2'b00}) begin
      n_bad++; $display("FAIL b2b_probe got cyc=%0d index=%h hwe=%b stall=%b expected 4 00000002 0 0",
        cyc, index_o, entryhi_we_o, stall_o);
    end
    step();
    n_cmp++;
    if ({stall_o, done_o} !== 2'b10) begin
      n_bad++; $display("FAIL b2b_accept got stall=%b done=%b expected 1 0", stall_o, done_o);
    end
    step();
    op_valid_i = 1'b0;
    n_cmp++;
    if (tlb_rd_idx_o !== 4'd9) begin n_bad++; $display("FAIL b2b_read_idx got %0d expected 9", tlb_rd_idx_o); end
    step();
    n_cmp++;
    if ({done_o, entryhi_we_o, index_we_o, entryhi_o, index_o} !== {3'b110, 32'h0040_2055, 32'd2}) begin
      n_bad++; $display("FAIL b2b_tlbr got done=%b hwe=%b iwe=%b hi=%h index=%h expected 1 1 0 00402055 00000002",
        done_o, entryhi_we_o, index_we_o, entryhi_o, index_o);
    end
    step();
  endtask

  initial begin
    init_mem();
    test_reset();
    test_tlbr();
    test_probe_hit3();
    test_probe_miss();
    test_probe_global();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
